hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Produces the `stall` input consumed by the pipeline's control decoder, together with the PC/IF-ID write enables and the pipeline-register flush and freeze controls.
- Detects three conditions:
  - load-use data hazards (ID vs EX);
  - taken branches and jumps resolved in MEM;
  - multi-cycle data-memory accesses in MEM, which freeze the whole pipeline.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
MEM_LATENCY, 1, cycles a load/store occupies MEM; 1 = single-cycle memory, never freezes; legal range 1..16
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ifid_opcode  in  7  opcode of the instruction in IF/ID
ifid_rs1  in  5  rs1 field in IF/ID
ifid_rs2  in  5  rs2 field in IF/ID
idex_rd  in  5  destination register in ID/EX
idex_memread  in  1  MemRead of the instruction in ID/EX
mem_branch_taken  in  1  taken branch or jal currently in MEM
mem_access  in  1  MemRead|MemWrite of the instruction in MEM
stall  out  1  to control decoder; forces a bubble into ID/EX
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
flush_ifid  out  1  clear IF/ID
flush_idex  out  1  clear ID/EX
flush_exmem  out  1  clear EX/MEM
freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers
stall_cycles  out  CNT_W  saturating count of cycles with stall|freeze
flush_events  out  CNT_W  saturating count of cycles with flush_ifid

Behaviour:
- Register source usage decoded from ifid_opcode:
  - 0110011, 0100011, 1100011: rs1 and rs2
  - 0000011, 0010011: rs1 only
  - 1101111 and all other opcodes: neither
- load_use = idex_memread & (idex_rd != 0) & ((uses_rs1 & rs1==idex_rd) | (uses_rs2 & rs2==idex_rd)).
- FSM states: RUN, WAIT. Wait counter wcnt is 4 bits.
  - RUN, mem_access=1 and MEM_LATENCY>1: freeze=1 this cycle; wcnt<=MEM_LATENCY-2; next state WAIT.
  - WAIT, wcnt!=0: freeze=1; wcnt decrements.
  - WAIT, wcnt==0: release cycle. freeze=0, the access completes, next state RUN. This cycle is evaluated exactly as a RUN cycle with mem_access ignored.
  - Result: an access sees freeze for MEM_LATENCY-1 cycles, then advances. A back-to-back access re-enters WAIT on the next cycle.
- Output priority, all combinational from state and inputs (Mealy), same cycle:
  1. freeze=1: pc_write=0, ifid_write=0; stall and all flushes 0.
  2. else mem_branch_taken: flush_ifid=flush_idex=flush_exmem=1, pc_write=1, ifid_write=1, stall=0. load_use is ignored.
  3. else load_use: stall=1, pc_write=0, ifid_write=0; flushes 0. One bubble per hazard, since the load advances to MEM next cycle.
  4. else: pc_write=ifid_write=1; all others 0.
- Counters, updated on the rising edge:
  - stall_cycles increments when (stall|freeze)=1.
  - flush_events increments when flush_ifid=1.
  - Both saturate at all-ones; no wrap.
- Reset, asynchronous and effective immediately, including mid-WAIT:
  - state RUN, wcnt 0, counters 0.
  - While reset is high, outputs are forced to: stall 0, freeze 0, flushes 0, pc_write 1, ifid_write 1.
- mem_branch_taken together with mem_access in the same cycle cannot occur; the branch is not checked against it.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_opcode=0110011, ifid_rs2=5 -> stall=1, pc_write=0, ifid_write=0 for exactly 1 cycle; stall_cycles=1.
- No false hazard:
  - idex_rd=0 -> stall=0.
  - ifid_opcode=0010011, rs2=idex_rd=7 -> stall=0.
  - ifid_opcode=1101111 -> stall=0.
- Branch flush with a simultaneous load-use: mem_branch_taken=1 and load_use true -> all three flushes=1, stall=0, pc_write=1; flush_events=1.
- MEM_LATENCY=3, single-cycle mem_access pulse:
  - freeze=1 for 2 cycles, then 0 on the release cycle; state returns to RUN.
  - load_use held true throughout -> stall asserts only on the release cycle.
- Reset asserted in the first WAIT cycle (MEM_LATENCY=4) -> freeze drops the same cycle without a clock edge; counters 0; after release, a new mem_access produces the full 3-cycle freeze.
- Saturation: CNT_W=4, stall held for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, MEM-resolved branch flush and
// multi-cycle memory freeze, plus saturating stall/flush event counters.
module hazard_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       ifid_opcode,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    // Freeze cycles after the first one, minus the release cycle.
    localparam logic [3:0] WAIT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;
    localparam logic       MULTI_CYCLE = (MEM_LATENCY > 1);

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic uses_rs1, uses_rs2, load_use, freeze_fsm;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (ifid_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0000011, 7'b0010011: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((uses_rs1 && (ifid_rs1 == idex_rd)) ||
                       (uses_rs2 && (ifid_rs2 == idex_rd)));

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        freeze_fsm = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mem_access && MULTI_CYCLE) begin
                    freeze_fsm = 1'b1;
                    wcnt_d     = WAIT_INIT;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // wcnt==0 is the release cycle; mem_access is ignored here.
                if (wcnt_q != 4'd0) begin
                    freeze_fsm = 1'b1;
                    wcnt_d     = wcnt_q - 4'd1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        freeze      = 1'b0;
        if (!reset) begin
            if (freeze_fsm) begin
                freeze     = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (mem_branch_taken) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end else if (load_use) begin
                stall      = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if ((stall || freeze) && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (flush_ifid && (flush_events_q != {CNT_W{1'b1}}))
            flush_events_d = flush_events_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_RUN;
            wcnt_q         <= 4'd0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule
